// File: rtl/note_tone_player.sv
// note_tone_player: turns a latched 3-bit note index into a square-wave tone
// for a fixed sustain time after every strum toggle (rising or falling).
// The strum level is asynchronous and passes through a two-flop synchronizer
// plus one history flop for edge detection.
// Optional macro NOTE_TONE_DECAY_EN adds a 4-bit volume envelope with PWM gating.
module note_tone_player #(
    parameter int SUSTAIN_CYCLES    = 25000000,
    parameter int DIV_SHIFT         = 0,
    parameter int DECAY_STEP_CYCLES = 1562500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] note_code,
    input  logic       strum,
    output logic       audio_out,
    output logic       playing,
    output logic [2:0] note_out
);

    localparam int SUS_W = (SUSTAIN_CYCLES > 2) ? $clog2(SUSTAIN_CYCLES) : 1;
    localparam logic [SUS_W-1:0] SUS_LAST = SUS_W'(SUSTAIN_CYCLES - 1);

    // Half-period base values in clk cycles (C4..B4); index 7 repeats B4.
    localparam logic [16:0] HP_BASE [0:7] = '{
        17'd95556, 17'd85132, 17'd75843, 17'd71586,
        17'd63776, 17'd56818, 17'd50620, 17'd50620
    };

    typedef enum logic {IDLE, PLAY} state_t;

    // Reject configurations the counters cannot represent.
    if (SUSTAIN_CYCLES < 2) begin : g_bad_sustain
        $error("SUSTAIN_CYCLES must be >= 2");
    end
    if (DECAY_STEP_CYCLES < 1) begin : g_bad_decay
        $error("DECAY_STEP_CYCLES must be >= 1");
    end

    logic [16:0] hp_table [0:7];

    for (genvar gi = 0; gi < 8; gi++) begin : g_hp
        assign hp_table[gi] = HP_BASE[gi] >> DIV_SHIFT;
    end

    logic             s1_reg, s2_reg, s3_reg;
    logic             pluck;
    logic [2:0]       note_clamped;
    logic [16:0]      hp_last;
    logic             vol_empty;

    state_t           state_reg,    state_next;
    logic [16:0]      half_cnt_reg, half_cnt_next;
    logic [SUS_W-1:0] sus_cnt_reg,  sus_cnt_next;
    logic             sq_reg,       sq_next;
    logic             playing_reg,  playing_next;
    logic [2:0]       note_reg,     note_next;

    // Synchronize the raw strum level; any change of the synced level is a pluck.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= strum;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign pluck        = s2_reg ^ s3_reg;
    assign note_clamped = (note_code == 3'd7) ? 3'd6 : note_code;
    assign hp_last      = hp_table[note_reg] - 17'd1;

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            half_cnt_reg <= '0;
            sus_cnt_reg  <= '0;
            sq_reg       <= 1'b0;
            playing_reg  <= 1'b0;
            note_reg     <= 3'd0;
        end else begin
            state_reg    <= state_next;
            half_cnt_reg <= half_cnt_next;
            sus_cnt_reg  <= sus_cnt_next;
            sq_reg       <= sq_next;
            playing_reg  <= playing_next;
            note_reg     <= note_next;
        end
    end

    // Next state: a pluck always restarts the note, even on the sustain's last cycle.
    always_comb begin
        state_next    = state_reg;
        half_cnt_next = half_cnt_reg;
        sus_cnt_next  = sus_cnt_reg;
        sq_next       = sq_reg;
        playing_next  = playing_reg;
        note_next     = note_reg;
        if (pluck) begin
            state_next    = PLAY;
            half_cnt_next = '0;
            sus_cnt_next  = '0;
            sq_next       = 1'b0;
            playing_next  = 1'b1;
            note_next     = note_clamped;
        end else begin
            case (state_reg)
                IDLE: begin
                    half_cnt_next = '0;
                    sus_cnt_next  = '0;
                    sq_next       = 1'b0;
                    playing_next  = 1'b0;
                end
                PLAY: begin
                    if (sus_cnt_reg == SUS_LAST || vol_empty) begin
                        state_next    = IDLE;
                        half_cnt_next = '0;
                        sus_cnt_next  = '0;
                        sq_next       = 1'b0;
                        playing_next  = 1'b0;
                    end else begin
                        sus_cnt_next = sus_cnt_reg + SUS_W'(1);
                        if (half_cnt_reg == hp_last) begin
                            half_cnt_next = '0;
                            sq_next       = ~sq_reg;
                        end else begin
                            half_cnt_next = half_cnt_reg + 17'd1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef NOTE_TONE_DECAY_EN
    localparam int DEC_W = (DECAY_STEP_CYCLES > 2) ? $clog2(DECAY_STEP_CYCLES) : 1;
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_STEP_CYCLES - 1);

    logic [3:0]       volume_reg;
    logic [DEC_W-1:0] decay_cnt_reg;
    logic [3:0]       pwm_cnt_reg;

    // Volume envelope: full on pluck, one step down per decay period while playing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            volume_reg    <= 4'd0;
            decay_cnt_reg <= '0;
            pwm_cnt_reg   <= 4'd0;
        end else if (pluck) begin
            volume_reg    <= 4'd15;
            decay_cnt_reg <= '0;
            pwm_cnt_reg   <= 4'd0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 4'd1;
            if (state_reg == PLAY) begin
                if (decay_cnt_reg == DEC_LAST) begin
                    decay_cnt_reg <= '0;
                    if (volume_reg != 4'd0) begin
                        volume_reg <= volume_reg - 4'd1;
                    end
                end else begin
                    decay_cnt_reg <= decay_cnt_reg + DEC_W'(1);
                end
            end else begin
                decay_cnt_reg <= '0;
            end
        end
    end

    assign vol_empty = (state_reg == PLAY) && (volume_reg == 4'd0);
    assign audio_out = sq_reg & (pwm_cnt_reg < volume_reg);
`else
    assign vol_empty = 1'b0;
    assign audio_out = sq_reg;
`endif

    assign playing  = playing_reg;
    assign note_out = note_reg;

endmodule
